// File: rtl/wb_stage_if.sv
// MEM -> write-back stage bus: instruction handoff, memory load response and flush.
interface wb_stage_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RA_W = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [RA_W-1:0] in_rd;
  logic            in_wen;
  logic [1:0]      in_sel;
  logic [XLEN-1:0] in_alu;
  logic [XLEN-1:0] in_pc4;
  logic [XLEN-1:0] in_imm;
  logic [1:0]      in_ld_size;
  logic            in_ld_uns;
  logic [1:0]      in_addr_lo;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;
  logic            flush;

  modport master (
    output in_valid, in_rd, in_wen, in_sel, in_alu, in_pc4, in_imm,
           in_ld_size, in_ld_uns, in_addr_lo, mem_rvalid, mem_rdata, flush,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_rd, in_wen, in_sel, in_alu, in_pc4, in_imm,
           in_ld_size, in_ld_uns, in_addr_lo, mem_rvalid, mem_rdata, flush,
    output in_ready
  );
endinterface

// File: rtl/wb_stage.sv
// RV32/RV64 write-back stage: source select, load wait/extend, register-file write, perf counters.
// Byte/half lane select and sign/zero extension of loads are built only when WB_LOAD_EXT_EN is defined.
module wb_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RA_W  = 5,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  wb_stage_if.slave        bus,
  output logic             rf_we,
  output logic [RA_W-1:0]  rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic             ld_pending,
  output logic [RA_W-1:0]  ld_rd,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {IDLE = 1'b0, WAIT_MEM = 1'b1} state_t;

  localparam logic [1:0] SEL_ALU = 2'b00;
  localparam logic [1:0] SEL_LD  = 2'b01;
  localparam logic [1:0] SEL_PC4 = 2'b10;
  localparam logic [1:0] SEL_IMM = 2'b11;

  state_t          state, state_nxt;
  logic            accept_c;
  logic            ld_wen_q;
  logic [XLEN-1:0] sel_data_c;
  logic [XLEN-1:0] ld_data_c;

  logic            rf_we_nxt;
  logic [RA_W-1:0] rf_waddr_nxt;
  logic [XLEN-1:0] rf_wdata_nxt;
  logic            ld_latch_c;
  logic            retire_inc_c;
  logic            stall_inc_c;

  assign bus.in_ready = (state == IDLE);
  assign accept_c     = bus.in_valid & (state == IDLE) & ~bus.flush;

  // Non-load source select
  always_comb begin
    sel_data_c = bus.in_alu;
    unique case (bus.in_sel)
      SEL_ALU: sel_data_c = bus.in_alu;
      SEL_PC4: sel_data_c = bus.in_pc4;
      SEL_IMM: sel_data_c = bus.in_imm;
      default: sel_data_c = bus.in_alu;
    endcase
  end

`ifdef WB_LOAD_EXT_EN
  logic [1:0] ld_size_q;
  logic       ld_uns_q;
  logic [1:0] ld_lo_q;
  logic [7:0]  byte_c;
  logic [15:0] half_c;
  logic [31:0] word_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_size_q <= 2'b00;
      ld_uns_q  <= 1'b0;
      ld_lo_q   <= 2'b00;
    end else if (ld_latch_c) begin
      ld_size_q <= bus.in_ld_size;
      ld_uns_q  <= bus.in_ld_uns;
      ld_lo_q   <= bus.in_addr_lo;
    end
  end

  // Lane select, then sign or zero extension to XLEN
  always_comb begin
    byte_c    = bus.mem_rdata[{ld_lo_q, 3'b000} +: 8];
    half_c    = bus.mem_rdata[{ld_lo_q[1], 4'b0000} +: 16];
    word_c    = bus.mem_rdata[31:0];
    ld_data_c = bus.mem_rdata;
    unique case (ld_size_q)
      2'b00:   ld_data_c = ld_uns_q ? XLEN'(byte_c) : XLEN'($signed(byte_c));
      2'b01:   ld_data_c = ld_uns_q ? XLEN'(half_c) : XLEN'($signed(half_c));
      2'b10:   ld_data_c = ld_uns_q ? XLEN'(word_c) : XLEN'($signed(word_c));
      default: ld_data_c = bus.mem_rdata;
    endcase
  end
`else
  assign ld_data_c = bus.mem_rdata;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (accept_c && bus.in_sel == SEL_LD) state_nxt = WAIT_MEM;
      WAIT_MEM: if (bus.flush || bus.mem_rvalid)      state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Write-port and counter updates; a flush in WAIT_MEM drops the load and any coincident response
  always_comb begin
    rf_we_nxt    = 1'b0;
    rf_waddr_nxt = rf_waddr;
    rf_wdata_nxt = rf_wdata;
    ld_latch_c   = 1'b0;
    retire_inc_c = 1'b0;
    stall_inc_c  = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept_c) begin
          if (bus.in_sel == SEL_LD) begin
            ld_latch_c = 1'b1;
          end else begin
            rf_we_nxt    = bus.in_wen & (bus.in_rd != '0);
            rf_waddr_nxt = bus.in_rd;
            rf_wdata_nxt = sel_data_c;
            retire_inc_c = 1'b1;
          end
        end
      end
      WAIT_MEM: begin
        if (!bus.flush) begin
          if (bus.mem_rvalid) begin
            rf_we_nxt    = ld_wen_q & (ld_rd != '0);
            rf_waddr_nxt = ld_rd;
            rf_wdata_nxt = ld_data_c;
            retire_inc_c = 1'b1;
          end else begin
            stall_inc_c  = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      ld_pending <= 1'b0;
      ld_rd      <= '0;
      ld_wen_q   <= 1'b0;
      retire_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      rf_we      <= rf_we_nxt;
      rf_waddr   <= rf_waddr_nxt;
      rf_wdata   <= rf_wdata_nxt;
      ld_pending <= (state_nxt == WAIT_MEM);
      if (ld_latch_c) begin
        ld_rd    <= bus.in_rd;
        ld_wen_q <= bus.in_wen;
      end
      if (retire_inc_c) retire_cnt <= retire_cnt + CNT_W'(1);
      if (stall_inc_c)  stall_cnt  <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus random traffic against a behavioural model.
module tb_wb_stage;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned RA_W  = 5;
  localparam int unsigned CNT_W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_stage_if #(.XLEN(XLEN), .RA_W(RA_W)) bus ();

  logic             rf_we;
  logic [RA_W-1:0]  rf_waddr;
  logic [XLEN-1:0]  rf_wdata;
  logic             ld_pending;
  logic [RA_W-1:0]  ld_rd;
  logic [CNT_W-1:0] retire_cnt;
  logic [CNT_W-1:0] stall_cnt;

  wb_stage #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .ld_pending (ld_pending),
    .ld_rd      (ld_rd),
    .retire_cnt (retire_cnt),
    .stall_cnt  (stall_cnt)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: a pending-load record plus the expected visible outputs
  bit          m_pend;
  int unsigned m_rd, m_size, m_lo;
  bit          m_wen, m_uns;
  bit          e_we;
  int unsigned e_waddr, e_wdata, e_ret, e_stall;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned load_value(input int unsigned rdata, input int unsigned size,
                                             input bit uns, input int unsigned lo);
    int unsigned v;
`ifdef WB_LOAD_EXT_EN
    if (size == 0) begin
      v = (rdata >> (8 * lo)) % 256;
      if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (size == 1) begin
      v = (rdata >> (16 * (lo / 2))) % 65536;
      if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = rdata;
    end
`else
    v = rdata + 0 * (size + lo + int'(uns));
`endif
    return v;
  endfunction

  function automatic int unsigned pick_source(input int unsigned sel);
    if (sel == 2) return bus.in_pc4;
    if (sel == 3) return bus.in_imm;
    return bus.in_alu;
  endfunction

  task automatic model_reset();
    m_pend = 0; m_rd = 0; m_size = 0; m_lo = 0; m_wen = 0; m_uns = 0;
    e_we = 0; e_waddr = 0; e_wdata = 0; e_ret = 0; e_stall = 0;
  endtask

  task automatic model_step();
    e_we = 0;
    if (!m_pend) begin
      if (bus.in_valid && !bus.flush) begin
        if (bus.in_sel == 2'b01) begin
          m_pend = 1; m_rd = bus.in_rd; m_wen = bus.in_wen;
          m_size = bus.in_ld_size; m_uns = bus.in_ld_uns; m_lo = bus.in_addr_lo;
        end else begin
          e_we    = bus.in_wen && (bus.in_rd != 0);
          e_waddr = bus.in_rd;
          e_wdata = pick_source(bus.in_sel);
          e_ret++;
        end
      end
    end else if (bus.flush) begin
      m_pend = 0;
    end else if (bus.mem_rvalid) begin
      m_pend  = 0;
      e_we    = m_wen && (m_rd != 0);
      e_waddr = m_rd;
      e_wdata = load_value(bus.mem_rdata, m_size, m_uns, m_lo);
      e_ret++;
    end else begin
      e_stall++;
    end
  endtask

  task automatic compare_all();
    check("rf_we", rf_we, e_we);
    if (e_we) begin
      check("rf_waddr", rf_waddr, e_waddr);
      check("rf_wdata", rf_wdata, e_wdata);
    end
    check("ld_pending", ld_pending, m_pend);
    check("in_ready", bus.in_ready, !m_pend);
    if (m_pend) check("ld_rd", ld_rd, m_rd);
    check("retire_cnt", retire_cnt, e_ret);
    check("stall_cnt", stall_cnt, e_stall);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    bus.in_valid = 0; bus.in_rd = '0; bus.in_wen = 0; bus.in_sel = 2'b00;
    bus.in_alu = '0; bus.in_pc4 = '0; bus.in_imm = '0;
    bus.in_ld_size = 2'b00; bus.in_ld_uns = 0; bus.in_addr_lo = 2'b00;
    bus.mem_rvalid = 0; bus.mem_rdata = '0; bus.flush = 0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rf_we"}, rf_we, 0);
    check({tag, "_rf_waddr"}, rf_waddr, 0);
    check({tag, "_rf_wdata"}, rf_wdata, 0);
    check({tag, "_ld_pending"}, ld_pending, 0);
    check({tag, "_ld_rd"}, ld_rd, 0);
    check({tag, "_in_ready"}, bus.in_ready, 1);
    check({tag, "_retire"}, retire_cnt, 0);
    check({tag, "_stall"}, stall_cnt, 0);
  endtask

  task automatic issue_byte_load(input bit uns);
    bus.in_valid = 1; bus.in_sel = 2'b01; bus.in_rd = 5'd7; bus.in_wen = 1;
    bus.in_ld_size = 2'b00; bus.in_ld_uns = uns; bus.in_addr_lo = 2'd3;
    cycle();
    idle_inputs();
  endtask

  task automatic byte_load_test(input bit uns, input int unsigned exp_data);
    int unsigned s0;
    s0 = e_stall;
    issue_byte_load(uns);
    cycle();
    check("tp_ld_ready_wait1", bus.in_ready, 0);
    cycle();
    check("tp_ld_ready_wait2", bus.in_ready, 0);
    bus.mem_rvalid = 1; bus.mem_rdata = 32'h8000_0000;
    cycle();
    idle_inputs();
    check("tp_ld_we", rf_we, 1);
    check("tp_ld_waddr", rf_waddr, 7);
    check("tp_ld_data", rf_wdata, exp_data);
    check("tp_ld_stall", stall_cnt, s0 + 2);
    check("tp_ld_ready_after", bus.in_ready, 1);
  endtask

  initial begin
    int unsigned r0;
    idle_inputs();
    model_reset();
    rst_n = 0;
    #12;
    check_reset_values("reset");
    rst_n = 1;

    // ALU op rd=5
    bus.in_valid = 1; bus.in_sel = 2'b00; bus.in_rd = 5'd5; bus.in_wen = 1; bus.in_alu = 32'h1;
    cycle();
    idle_inputs();
    check("tp_alu_we", rf_we, 1);
    check("tp_alu_waddr", rf_waddr, 5);
    check("tp_alu_data", rf_wdata, 32'h1);
    check("tp_alu_retire", retire_cnt, 1);

    // Back-to-back PC+4 then immediate
    bus.in_valid = 1; bus.in_sel = 2'b10; bus.in_rd = 5'd3; bus.in_wen = 1; bus.in_pc4 = 32'h104;
    cycle();
    check("tp_pc4_data", rf_wdata, 32'h104);
    bus.in_sel = 2'b11; bus.in_imm = 32'h2;
    cycle();
    idle_inputs();
    check("tp_imm_we", rf_we, 1);
    check("tp_imm_data", rf_wdata, 32'h2);
    cycle();
    check("tp_we_pulse", rf_we, 0);

`ifdef WB_LOAD_EXT_EN
    byte_load_test(0, 32'hFFFF_FF80);
    byte_load_test(1, 32'h0000_0080);
`else
    byte_load_test(0, 32'h8000_0000);
    byte_load_test(1, 32'h8000_0000);
`endif

    // Flush coincident with the load response
    issue_byte_load(0);
    cycle();
    bus.flush = 1; bus.mem_rvalid = 1; bus.mem_rdata = 32'h1234_5678;
    cycle();
    idle_inputs();
    check("tp_flush_we", rf_we, 0);
    check("tp_flush_pending", ld_pending, 0);
    check("tp_flush_ready", bus.in_ready, 1);

    // rd=0 retires without writing
    r0 = e_ret;
    bus.in_valid = 1; bus.in_sel = 2'b00; bus.in_rd = '0; bus.in_wen = 1; bus.in_alu = 32'hDEAD;
    cycle();
    idle_inputs();
    check("tp_rd0_we", rf_we, 0);
    check("tp_rd0_retire", retire_cnt, r0 + 1);

    // Asynchronous reset while a load is outstanding
    issue_byte_load(0);
    check("tp_mid_pending", ld_pending, 1);
    rst_n = 0;
    #1;
    check_reset_values("async_reset");
    model_reset();
    #2;
    rst_n = 1;
    cycle();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      bus.in_valid   = ($urandom_range(0, 9) < 7);
      bus.in_sel     = 2'($urandom_range(0, 3));
      bus.in_rd      = ($urandom_range(0, 7) == 0) ? '0 : RA_W'($urandom);
      bus.in_wen     = ($urandom_range(0, 7) != 0);
      bus.in_alu     = $urandom;
      bus.in_pc4     = $urandom;
      bus.in_imm     = $urandom;
      bus.in_ld_size = 2'($urandom_range(0, 2));
      bus.in_ld_uns  = 1'($urandom);
      bus.in_addr_lo = 2'($urandom);
      bus.mem_rvalid = ($urandom_range(0, 9) < 4);
      bus.mem_rdata  = $urandom;
      bus.flush      = ($urandom_range(0, 9) == 0);
      cycle();
    end
    idle_inputs();
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
